// File: rtl/cnv_row_acc_pkg.sv
// cnv_row_acc_pkg
//   Shared definitions for the row-accumulation stage:
//   - state_t : FSM state encoding (IDLE=0, ACC=1, DRAIN=2)
//   - DEF_*   : default row length and datapath widths
//   - clog2   : constant function used to size the pixel counters
package cnv_row_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_LENROW     = 16;
  localparam int DEF_MAC_WIDTH  = 23;
  localparam int DEF_PSUM_WIDTH = 24;

  // Bits needed to index 0..value-1 (value >= 2).
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cnv_row_acc_if.sv
// cnv_row_acc_if
//   Valid/ready drain port carrying finished partial sums.
//   out_vld  : out_psum/out_last valid (master -> slave)
//   out_rdy  : slave accepts the current pixel (slave -> master)
//   out_psum : signed partial sum, pixel order 0..LENROW-1
//   out_last : marks the final pixel of the row
interface cnv_row_acc_if
  import cnv_row_acc_pkg::*;
#(
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH
);
  logic                  out_vld;
  logic                  out_rdy;
  logic [PSUM_WIDTH-1:0] out_psum;
  logic                  out_last;

  modport master (output out_vld, output out_psum, output out_last, input out_rdy);
  modport slave  (input out_vld, input out_psum, input out_last, output out_rdy);
endinterface

// File: rtl/cnv_row_acc_sat_add.sv
// cnv_row_acc_sat_add
//   Combinational signed add of two operands of arbitrary width, clamped to
//   an OUT-bit signed range. OUT must not exceed max(IN_A, IN_B) + 1.
//   a   : signed operand, IN_A bits
//   b   : signed operand, IN_B bits
//   sum : clamped signed result, OUT bits
//   sat : high when clamping changed the result
module cnv_row_acc_sat_add
  import cnv_row_acc_pkg::*;
#(
  parameter int IN_A = DEF_MAC_WIDTH,
  parameter int IN_B = DEF_PSUM_WIDTH,
  parameter int OUT  = DEF_PSUM_WIDTH
) (
  input  logic [IN_A-1:0] a,
  input  logic [IN_B-1:0] b,
  output logic [OUT-1:0]  sum,
  output logic            sat
);
  // One guard bit above the wider operand makes the raw sum exact.
  localparam int SW = ((IN_A > IN_B) ? IN_A : IN_B) + 1;

  logic [SW-1:0]  a_ext;
  logic [SW-1:0]  b_ext;
  logic [SW-1:0]  raw;
  logic [SW-OUT:0] top;

  assign a_ext = {{(SW-IN_A){a[IN_A-1]}}, a};
  assign b_ext = {{(SW-IN_B){b[IN_B-1]}}, b};
  assign raw   = a_ext + b_ext;

  // The result fits in OUT bits only if every bit from the OUT sign bit up
  // to the guard bit carries the same value.
  assign top = raw[SW-1:OUT-1];
  assign sat = !((&top) || !(|top));

  always_comb begin
    sum = raw[OUT-1:0];
    if (sat) begin
      sum = raw[SW-1] ? {1'b1, {(OUT-1){1'b0}}} : {1'b0, {(OUT-1){1'b1}}};
    end
  end

endmodule

// File: rtl/cnv_row_acc.sv
// cnv_row_acc
//   Row-accumulation stage: adds each MAC-chain result to the partial sum of
//   the previous kernel row (or takes it alone on the first row), saturates
//   it into a LENROW-deep row buffer, then drains the row over valid/ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   row_sta    : start a new row (IDLE, or together with the final drain handshake)
//   row_first  : sampled with row_sta; 1 = ignore psum_in for the whole row
//   mac_vld    : mac_sum/psum_in valid for the current pixel
//   mac_sum    : signed MAC result
//   psum_in    : signed partial sum from the previous row
//   busy       : FSM not idle
//   row_fnh    : one-cycle pulse when the buffer is full and drain begins
//   sat_flag   : sticky per row, some pixel was clamped
//   drop_err   : sticky until reset, mac_vld seen outside accumulation
//   out_if     : drain port (out_vld/out_rdy/out_psum/out_last)
module cnv_row_acc
  import cnv_row_acc_pkg::*;
#(
  parameter int LENROW     = DEF_LENROW,
  parameter int MAC_WIDTH  = DEF_MAC_WIDTH,
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  row_sta,
  input  logic                  row_first,
  input  logic                  mac_vld,
  input  logic [MAC_WIDTH-1:0]  mac_sum,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  output logic                  busy,
  output logic                  row_fnh,
  output logic                  sat_flag,
  output logic                  drop_err,
  cnv_row_acc_if.master         out_if
);
  localparam int CNT_W = clog2(LENROW);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LENROW - 1);

  state_t state_reg;
  state_t state_next;

  logic [CNT_W-1:0]      wr_cnt_reg;
  logic [CNT_W-1:0]      rd_cnt_reg;
  logic                  first_reg;
  logic                  sat_flag_reg;
  logic                  drop_err_reg;
  logic                  row_fnh_reg;
  logic [PSUM_WIDTH-1:0] row_buf [LENROW];

  logic [PSUM_WIDTH-1:0] acc_b;
  logic [PSUM_WIDTH-1:0] acc_res;
  logic                  acc_sat;

  logic acc_wr;
  logic acc_done;
  logic drain_hs;
  logic drain_done;
  logic row_start;

  assign acc_wr     = (state_reg == ST_ACC) && mac_vld;
  assign acc_done   = acc_wr && (wr_cnt_reg == LAST_IDX);
  // out_vld is high throughout DRAIN, so out_rdy alone completes a handshake.
  assign drain_hs   = (state_reg == ST_DRAIN) && out_if.out_rdy;
  assign drain_done = drain_hs && (rd_cnt_reg == LAST_IDX);
  assign row_start  = row_sta && ((state_reg == ST_IDLE) || drain_done);

  assign acc_b = first_reg ? '0 : psum_in;

  cnv_row_acc_sat_add #(
    .IN_A (MAC_WIDTH),
    .IN_B (PSUM_WIDTH),
    .OUT  (PSUM_WIDTH)
  ) u_sat_add (
    .a   (mac_sum),
    .b   (acc_b),
    .sum (acc_res),
    .sat (acc_sat)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (row_sta) state_next = ST_ACC;
      ST_ACC:   if (acc_done) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_next = row_sta ? ST_ACC : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy            = (state_reg != ST_IDLE);
    out_if.out_vld  = (state_reg == ST_DRAIN);
    out_if.out_last = (state_reg == ST_DRAIN) && (rd_cnt_reg == LAST_IDX);
    out_if.out_psum = (state_reg == ST_DRAIN) ? row_buf[rd_cnt_reg] : '0;
  end

  assign row_fnh  = row_fnh_reg;
  assign sat_flag = sat_flag_reg;
  assign drop_err = drop_err_reg;

  // Counters and row flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_reg   <= '0;
      rd_cnt_reg   <= '0;
      first_reg    <= 1'b0;
      sat_flag_reg <= 1'b0;
      drop_err_reg <= 1'b0;
      row_fnh_reg  <= 1'b0;
    end else begin
      row_fnh_reg <= acc_done;

      // row_start and acc_wr belong to different states, never both high.
      if (row_start) begin
        first_reg    <= row_first;
        wr_cnt_reg   <= '0;
        sat_flag_reg <= 1'b0;
      end else if (acc_wr) begin
        wr_cnt_reg <= acc_done ? '0 : wr_cnt_reg + 1'b1;
        if (acc_sat) sat_flag_reg <= 1'b1;
      end

      if (acc_done) begin
        rd_cnt_reg <= '0;
      end else if (drain_hs) begin
        rd_cnt_reg <= drain_done ? '0 : rd_cnt_reg + 1'b1;
      end

      if (mac_vld && (state_reg != ST_ACC)) drop_err_reg <= 1'b1;
    end
  end

  // Row buffer: one register word per pixel, cleared by reset.
  for (genvar gi = 0; gi < LENROW; gi++) begin : g_buf
    logic [PSUM_WIDTH-1:0] cell_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cell_reg <= '0;
      end else if (acc_wr && (wr_cnt_reg == CNT_W'(gi))) begin
        cell_reg <= acc_res;
      end
    end

    assign row_buf[gi] = cell_reg;
  end

endmodule

// File: tb/tb_cnv_row_acc.sv
module tb_cnv_row_acc;
  localparam int LENROW = 4;
  localparam int MAC_W  = 23;
  localparam int PSUM_W = 24;
  localparam longint PMAX = 64'sd8388607;
  localparam longint PMIN = -64'sd8388608;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              row_sta = 1'b0;
  logic              row_first = 1'b0;
  logic              mac_vld = 1'b0;
  logic [MAC_W-1:0]  mac_sum = '0;
  logic [PSUM_W-1:0] psum_in = '0;
  logic              busy, row_fnh, sat_flag, drop_err;

  cnv_row_acc_if #(.PSUM_WIDTH(PSUM_W)) sif();

  cnv_row_acc #(.LENROW(LENROW), .MAC_WIDTH(MAC_W), .PSUM_WIDTH(PSUM_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_sta   (row_sta),
    .row_first (row_first),
    .mac_vld   (mac_vld),
    .mac_sum   (mac_sum),
    .psum_in   (psum_in),
    .busy      (busy),
    .row_fnh   (row_fnh),
    .sat_flag  (sat_flag),
    .drop_err  (drop_err),
    .out_if    (sif.master)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  int mac_a [LENROW];
  int psum_a [LENROW];

  bit obs_busy_sta, obs_fnh0, obs_vld0, obs_fnh1, obs_sat, obs_busy_end, obs_timeout;
  int obs_cycles, obs_stall_viol, obs_vld_gap;
  logic [PSUM_W-1:0] got_psum [$];
  logic              got_last [$];

  // Reference: exact integer sum clamped to the 24-bit signed range.
  function automatic logic [PSUM_W-1:0] model_acc(input int mac, input int psum, input bit first);
    longint s;
    s = longint'(mac) + (first ? 64'sd0 : longint'(psum));
    if (s > PMAX) s = PMAX;
    if (s < PMIN) s = PMIN;
    return s[PSUM_W-1:0];
  endfunction

  function automatic bit model_sat(input int mac, input int psum, input bit first);
    longint s;
    s = longint'(mac) + (first ? 64'sd0 : longint'(psum));
    return (s > PMAX) || (s < PMIN);
  endfunction

  function automatic int rand_mac();
    int v;
    v = int'($urandom);
    return (v <<< 9) >>> 9;
  endfunction

  function automatic int rand_psum();
    int v;
    v = int'($urandom);
    return (v <<< 8) >>> 8;
  endfunction

  // Runs one row: optional start pulse, LENROW pixels, then a drain with
  // out_rdy either held high (rdy_mode 0) or cycling 1,0,0,1 (rdy_mode 1).
  // Only records observations; the calling test judges them.
  task automatic do_row(input bit first, input int rdy_mode, input bit skip_start,
                        input bit mid_sta, input bit b2b_next, input bit b2b_first);
    bit rdy_pat [4];
    bit prev_stalled;
    logic [PSUM_W-1:0] prev_psum;
    int hs;
    int cyc;
    rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
    got_psum.delete();
    got_last.delete();
    obs_stall_viol = 0;
    obs_vld_gap = 0;
    obs_fnh1 = 1'b0;
    if (!skip_start) begin
      row_sta = 1'b1;
      row_first = first;
      @(negedge clk);
      row_sta = 1'b0;
    end
    obs_busy_sta = busy;
    for (int i = 0; i < LENROW; i++) begin
      mac_vld = 1'b1;
      mac_sum = mac_a[i][MAC_W-1:0];
      psum_in = psum_a[i][PSUM_W-1:0];
      if (mid_sta && i == 1) begin
        row_sta = 1'b1;
        row_first = ~first;
      end
      @(negedge clk);
      row_sta = 1'b0;
      row_first = first;
    end
    mac_vld = 1'b0;
    obs_fnh0 = row_fnh;
    obs_vld0 = sif.out_vld;
    obs_sat = sat_flag;
    hs = 0;
    cyc = 0;
    prev_stalled = 1'b0;
    prev_psum = '0;
    while (hs < LENROW && cyc < 40) begin
      sif.out_rdy = (rdy_mode == 0) ? 1'b1 : rdy_pat[cyc % 4];
      if (cyc == 1) obs_fnh1 = row_fnh;
      if (prev_stalled && sif.out_psum !== prev_psum) obs_stall_viol++;
      if (sif.out_vld !== 1'b1) obs_vld_gap++;
      if (sif.out_rdy && sif.out_vld) begin
        got_psum.push_back(sif.out_psum);
        got_last.push_back(sif.out_last);
        hs++;
        if (sif.out_last && b2b_next) begin
          row_sta = 1'b1;
          row_first = b2b_first;
        end
      end
      prev_stalled = sif.out_vld && !sif.out_rdy;
      prev_psum = sif.out_psum;
      @(negedge clk);
      row_sta = 1'b0;
      cyc++;
    end
    sif.out_rdy = 1'b0;
    obs_cycles = cyc;
    obs_timeout = (hs < LENROW);
    obs_busy_end = busy;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({busy, row_fnh, sif.out_vld, sif.out_last, sat_flag, drop_err} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got busy=%b fnh=%b vld=%b last=%b sat=%b drop=%b want all 0",
               busy, row_fnh, sif.out_vld, sif.out_last, sat_flag, drop_err);
    end
    tests_run++;
    if (sif.out_psum !== 24'h0) begin
      tests_failed++;
      $display("FAIL reset_psum got %h want 000000", sif.out_psum);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic();
    logic [PSUM_W-1:0] exp;
    for (int i = 0; i < LENROW; i++) begin
      mac_a[i] = i + 1;
      psum_a[i] = 10 * (i + 1);
    end
    do_row(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs_busy_sta !== 1'b1) begin
      tests_failed++; $display("FAIL basic_busy got %b want 1", obs_busy_sta);
    end
    tests_run++;
    if ({obs_fnh0, obs_vld0, obs_fnh1} !== 3'b110) begin
      tests_failed++; $display("FAIL basic_fnh got fnh0=%b vld0=%b fnh1=%b want 1 1 0", obs_fnh0, obs_vld0, obs_fnh1);
    end
    tests_run++;
    if (obs_timeout || obs_cycles != LENROW) begin
      tests_failed++; $display("FAIL basic_throughput got %0d cycles timeout=%b want %0d", obs_cycles, obs_timeout, LENROW);
    end
    for (int i = 0; i < LENROW; i++) begin
      exp = PSUM_W'(11 * (i + 1));
      tests_run++;
      if (got_psum[i] !== exp || got_last[i] !== (i == LENROW - 1)) begin
        tests_failed++; $display("FAIL basic_px%0d got %0d last=%b want %0d last=%b", i, got_psum[i], got_last[i], exp, (i == LENROW - 1));
      end
    end
    tests_run++;
    if (obs_sat !== 1'b0 || obs_busy_end !== 1'b0) begin
      tests_failed++; $display("FAIL basic_end got sat=%b busy=%b want 0 0", obs_sat, obs_busy_end);
    end
    $display("[TB] test_basic done");
  endtask

  task automatic test_first_row();
    for (int i = 0; i < LENROW; i++) begin
      mac_a[i] = -5;
      psum_a[i] = 32'h007F_FFFF;
    end
    do_row(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LENROW; i++) begin
      tests_run++;
      if (got_psum[i] !== 24'hFF_FFFB) begin
        tests_failed++; $display("FAIL first_px%0d got %h want fffffb", i, got_psum[i]);
      end
    end
    tests_run++;
    if (obs_sat !== 1'b0) begin
      tests_failed++; $display("FAIL first_sat got %b want 0", obs_sat);
    end
    $display("[TB] test_first_row done");
  endtask

  task automatic test_saturation();
    logic [PSUM_W-1:0] want [LENROW];
    mac_a[0] = 32'h100;  psum_a[0] = 32'h007F_FFF0;
    mac_a[1] = -1;       psum_a[1] = -32'h0080_0000;
    mac_a[2] = 7;        psum_a[2] = 100;
    mac_a[3] = -3;       psum_a[3] = 32'h007F_FFFF;
    want[0] = 24'h7F_FFFF; want[1] = 24'h80_0000; want[2] = 24'd107; want[3] = 24'h7F_FFFC;
    do_row(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LENROW; i++) begin
      tests_run++;
      if (got_psum[i] !== want[i]) begin
        tests_failed++; $display("FAIL sat_px%0d got %h want %h", i, got_psum[i], want[i]);
      end
    end
    tests_run++;
    if (obs_sat !== 1'b1) begin
      tests_failed++; $display("FAIL sat_flag got %b want 1", obs_sat);
    end
    $display("[TB] test_saturation done");
  endtask

  task automatic test_back_pressure();
    logic [PSUM_W-1:0] exp;
    for (int i = 0; i < LENROW; i++) begin
      mac_a[i] = rand_mac() >>> 4;
      psum_a[i] = rand_psum() >>> 4;
    end
    do_row(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs_stall_viol != 0 || obs_vld_gap != 0) begin
      tests_failed++; $display("FAIL bp_stable got %0d unstable %0d vld gaps want 0 0", obs_stall_viol, obs_vld_gap);
    end
    tests_run++;
    if (got_psum.size() != LENROW || obs_cycles != 8) begin
      tests_failed++; $display("FAIL bp_count got %0d handshakes in %0d cycles want %0d in 8", got_psum.size(), obs_cycles, LENROW);
    end
    for (int i = 0; i < LENROW; i++) begin
      exp = model_acc(mac_a[i], psum_a[i], 1'b0);
      tests_run++;
      if (got_psum[i] !== exp || got_last[i] !== (i == LENROW - 1)) begin
        tests_failed++; $display("FAIL bp_px%0d got %h last=%b want %h", i, got_psum[i], got_last[i], exp);
      end
    end
    $display("[TB] test_back_pressure done");
  endtask

  task automatic test_back_to_back();
    logic [PSUM_W-1:0] exp;
    // Row A saturates, so a stale sat_flag would leak into row B.
    for (int i = 0; i < LENROW; i++) begin
      mac_a[i] = 32'h1000;
      psum_a[i] = 32'h007F_FFFF;
    end
    do_row(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    tests_run++;
    if (obs_busy_end !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_busy got %b want 1", obs_busy_end);
    end
    // Row B: first-row mode from the overlapped start, plus a row_sta mid-ACC.
    for (int i = 0; i < LENROW; i++) begin
      mac_a[i] = rand_mac();
      psum_a[i] = rand_psum();
    end
    do_row(1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < LENROW; i++) begin
      exp = model_acc(mac_a[i], psum_a[i], 1'b1);
      tests_run++;
      if (got_psum[i] !== exp) begin
        tests_failed++; $display("FAIL b2b_px%0d got %h want %h", i, got_psum[i], exp);
      end
    end
    tests_run++;
    if ({obs_fnh0, obs_sat, obs_busy_end, obs_timeout} !== 4'b1000) begin
      tests_failed++; $display("FAIL b2b_end got fnh=%b sat=%b busy=%b timeout=%b want 1 0 0 0", obs_fnh0, obs_sat, obs_busy_end, obs_timeout);
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_drop_err();
    tests_run++;
    if (drop_err !== 1'b0) begin
      tests_failed++; $display("FAIL drop_pre got %b want 0", drop_err);
    end
    mac_vld = 1'b1;
    mac_sum = 23'h55;
    @(negedge clk);
    mac_vld = 1'b0;
    @(negedge clk);
    tests_run++;
    if (drop_err !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL drop_set got drop=%b busy=%b want 1 0", drop_err, busy);
    end
    $display("[TB] test_drop_err done");
  endtask

  task automatic test_reset_mid();
    logic [PSUM_W-1:0] exp;
    row_sta = 1'b1;
    row_first = 1'b0;
    @(negedge clk);
    row_sta = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mac_vld = 1'b1;
      mac_sum = 23'h1234;
      psum_in = 24'h5678;
      @(negedge clk);
    end
    mac_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, row_fnh, sif.out_vld, sif.out_last, sat_flag, drop_err} !== 6'b0 || sif.out_psum !== 24'h0) begin
      tests_failed++;
      $display("FAIL rstmid_out got busy=%b fnh=%b vld=%b last=%b sat=%b drop=%b psum=%h want all 0",
               busy, row_fnh, sif.out_vld, sif.out_last, sat_flag, drop_err, sif.out_psum);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < LENROW; i++) begin
      mac_a[i] = -(i + 1);
      psum_a[i] = 1000 * (i + 1);
    end
    do_row(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LENROW; i++) begin
      exp = PSUM_W'(999 * (i + 1));
      tests_run++;
      if (got_psum[i] !== exp) begin
        tests_failed++; $display("FAIL rstmid_px%0d got %0d want %0d", i, got_psum[i], exp);
      end
    end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_random();
    logic [PSUM_W-1:0] exp;
    bit first;
    bit exp_sat;
    int mode;
    int bad;
    for (int r = 0; r < 8; r++) begin
      first = 1'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 1));
      exp_sat = 1'b0;
      for (int i = 0; i < LENROW; i++) begin
        mac_a[i] = rand_mac();
        psum_a[i] = rand_psum();
        exp_sat |= model_sat(mac_a[i], psum_a[i], first);
      end
      do_row(first, mode, 1'b0, 1'b0, 1'b0, 1'b0);
      bad = 0;
      for (int i = 0; i < LENROW; i++) begin
        exp = model_acc(mac_a[i], psum_a[i], first);
        if (got_psum[i] !== exp || got_last[i] !== (i == LENROW - 1)) bad++;
      end
      tests_run++;
      if (bad != 0 || got_psum.size() != LENROW || obs_sat !== exp_sat || obs_stall_viol != 0) begin
        tests_failed++;
        $display("FAIL rand_row%0d got %0d bad px, %0d px, sat=%b, %0d unstable want 0, %0d, sat=%b, 0",
                 r, bad, got_psum.size(), obs_sat, obs_stall_viol, LENROW, exp_sat);
      end
      $display("[TB] random row %0d first=%b mode=%0d sat=%b", r, first, mode, exp_sat);
    end
    tests_run++;
    if (drop_err !== 1'b0) begin
      tests_failed++; $display("FAIL rand_drop got %b want 0", drop_err);
    end
  endtask

  initial begin
    sif.out_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_first_row();
    test_saturation();
    test_back_pressure();
    test_back_to_back();
    test_drop_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
